// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and stall freeze.
// Define PIPE_STAGE_SKID_EN to add a skid entry, which gives a fully registered o_ready.
module pipe_stage_reg #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] BUBBLE     = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occupancy
);

  logic                  main_valid_reg;
  logic                  main_valid_next;
  logic [DATA_WIDTH-1:0] main_data_reg;
  logic [DATA_WIDTH-1:0] main_data_next;
  logic                  accept;
  logic                  emit;

  // Stall masks both handshakes, so every register holds without an explicit hold term.
  assign o_valid = main_valid_reg & ~i_stall;
  assign o_data  = main_data_reg;
  assign emit    = o_valid & i_ready;
  assign accept  = i_valid & o_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic                  skid_valid_reg;
  logic                  skid_valid_next;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic [DATA_WIDTH-1:0] skid_data_next;

  assign o_ready     = ~skid_valid_reg & ~i_stall;
  assign o_occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (i_flush) begin
      main_valid_next = 1'b0;
      main_data_next  = BUBBLE;
      skid_valid_next = 1'b0;
      skid_data_next  = BUBBLE;
    end else if (emit && accept) begin
      // o_ready implies the skid is empty, so the new entry goes straight to main.
      main_data_next = i_data;
    end else if (emit) begin
      if (skid_valid_reg) begin
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
        skid_data_next  = BUBBLE;
      end else begin
        main_valid_next = 1'b0;
        main_data_next  = BUBBLE;
      end
    end else if (accept) begin
      if (main_valid_reg) begin
        skid_valid_next = 1'b1;
        skid_data_next  = i_data;
      end else begin
        main_valid_next = 1'b1;
        main_data_next  = i_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= BUBBLE;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= BUBBLE;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
    end
  end

`else

  // A full stage can take a new entry only when the held one leaves in the same cycle.
  assign o_ready     = (~main_valid_reg | i_ready) & ~i_stall;
  assign o_occupancy = {1'b0, main_valid_reg};

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    if (i_flush) begin
      main_valid_next = 1'b0;
      main_data_next  = BUBBLE;
    end else if (accept) begin
      main_valid_next = 1'b1;
      main_data_next  = i_data;
    end else if (emit) begin
      main_valid_next = 1'b0;
      main_data_next  = BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= BUBBLE;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expectations follow PIPE_STAGE_SKID_EN when it is defined.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam logic [DW-1:0] BUB = 16'h00B0;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_stall;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    o_occupancy;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_WIDTH(DW), .BUBBLE(BUB)) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_occupancy(o_occupancy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are settled 2 time units later.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    cycle(); cycle();
    rst = 1'b0; #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", o_valid); end
    total++; if (o_data !== BUB) begin bad++; $display("FAIL reset_data got=%0h want=%0h", o_data, BUB); end
    total++; if (o_occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", o_occupancy); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", o_ready); end
    i_valid = 1'b1; i_data = 16'h0033;
    cycle();
    i_valid = 1'b0; #1;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL held_valid got=%0h want=1", o_valid); end
    total++; if (o_data !== 16'h0033) begin bad++; $display("FAIL held_data got=%0h want=33", o_data); end
    rst = 1'b1; #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0h want=0", o_valid); end
    total++; if (o_data !== BUB) begin bad++; $display("FAIL midrst_data got=%0h want=%0h", o_data, BUB); end
    total++; if (o_occupancy !== 2'd0) begin bad++; $display("FAIL midrst_occ got=%0d want=0", o_occupancy); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0h want=1", o_ready); end
    #1 rst = 1'b0;
    cycle();
  endtask

  task automatic test_streaming();
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1; i_data = DW'(k); #1;
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL stream_ready k=%0d got=%0h want=1", k, o_ready); end
      cycle();
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%0h want=1", k, o_valid); end
      total++; if (o_data !== DW'(k)) begin bad++; $display("FAIL stream_data got=%0h want=%0h", o_data, k); end
    end
    i_valid = 1'b0;
    cycle();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%0h want=0", o_valid); end
    total++; if (o_data !== BUB) begin bad++; $display("FAIL stream_end_data got=%0h want=%0h", o_data, BUB); end
    total++; if (o_occupancy !== 2'd0) begin bad++; $display("FAIL stream_end_occ got=%0d want=0", o_occupancy); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b1; i_valid = 1'b1; i_data = 16'h000A;
    cycle();
    i_ready = 1'b0; i_data = 16'h000B; #1;
`ifdef PIPE_STAGE_SKID_EN
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_reg got=%0h want=1", o_ready); end
    cycle();
    total++; if (o_occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ2 got=%0d want=2", o_occupancy); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0h want=0", o_ready); end
    total++; if (o_data !== 16'h000A) begin bad++; $display("FAIL bp_hold_a got=%0h want=a", o_data); end
    i_ready = 1'b1; i_data = 16'h000C;
    cycle();
    total++; if (o_data !== 16'h000B) begin bad++; $display("FAIL bp_out_b got=%0h want=b", o_data); end
    total++; if (o_occupancy !== 2'd1) begin bad++; $display("FAIL bp_occ1 got=%0d want=1", o_occupancy); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0h want=1", o_ready); end
    cycle();
`else
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_comb got=%0h want=0", o_ready); end
    cycle();
    total++; if (o_occupancy !== 2'd1) begin bad++; $display("FAIL bp_occ1 got=%0d want=1", o_occupancy); end
    total++; if (o_data !== 16'h000A) begin bad++; $display("FAIL bp_hold_a got=%0h want=a", o_data); end
    i_ready = 1'b1; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0h want=1", o_ready); end
    cycle();
    total++; if (o_data !== 16'h000B) begin bad++; $display("FAIL bp_out_b got=%0h want=b", o_data); end
    i_data = 16'h000C;
    cycle();
`endif
    total++; if (o_data !== 16'h000C) begin bad++; $display("FAIL bp_out_c got=%0h want=c", o_data); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c got=%0h want=1", o_valid); end
    i_valid = 1'b0;
    cycle();
    total++; if (o_occupancy !== 2'd0) begin bad++; $display("FAIL bp_drain_occ got=%0d want=0", o_occupancy); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 16'h00D1;
    cycle();
    i_data = 16'h00D2;
    cycle();
`ifdef PIPE_STAGE_SKID_EN
    total++; if (o_occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d want=2", o_occupancy); end
`else
    total++; if (o_occupancy !== 2'd1) begin bad++; $display("FAIL flush_pre_occ got=%0d want=1", o_occupancy); end
`endif
    i_flush = 1'b1; i_data = 16'h000F; i_ready = 1'b1;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0; #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", o_valid); end
    total++; if (o_data !== BUB) begin bad++; $display("FAIL flush_data got=%0h want=%0h", o_data, BUB); end
    total++; if (o_occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", o_occupancy); end
    for (int n = 0; n < 3; n++) begin
      cycle();
      total++; if (o_valid !== 1'b0 || o_data === 16'h000F) begin bad++; $display("FAIL flush_leak valid=%0h data=%0h want valid=0", o_valid, o_data); end
    end
  endtask

  task automatic test_stall();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 16'h0005;
    cycle();
    i_stall = 1'b1; i_data = 16'h0006; i_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stall_valid n=%0d got=%0h want=0", n, o_valid); end
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready n=%0d got=%0h want=0", n, o_ready); end
      cycle();
      total++; if (o_data !== 16'h0005) begin bad++; $display("FAIL stall_data n=%0d got=%0h want=5", n, o_data); end
      total++; if (o_occupancy !== 2'd1) begin bad++; $display("FAIL stall_occ n=%0d got=%0d want=1", n, o_occupancy); end
    end
    i_stall = 1'b0; i_valid = 1'b0; #1;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%0h want=1", o_valid); end
    total++; if (o_data !== 16'h0005) begin bad++; $display("FAIL release_data got=%0h want=5", o_data); end
    cycle();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL release_dup got=%0h want=0", o_valid); end
    total++; if (o_occupancy !== 2'd0) begin bad++; $display("FAIL release_occ got=%0d want=0", o_occupancy); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
